ifetch_buf: RTL

Instruction fetch stage that sits directly downstream of the 32-bit PC register. It issues one instruction-memory read per PC value over a req/ack handshake and queues each returned word, tagged with its PC, in a small FIFO. It presents the FIFO head to the decode stage and drives the PC register's hold input so the PC advances only when a fetch completes. Decode stalls (loaddepen) and branch redirects are handled inside this block.

---
 rtl/ifetch_pkg.sv | 9 +
 rtl/fetch_fifo.sv | 41 ++++
 rtl/ifetch_buf.sv | 74 +++++++
 3 files changed

// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared types and widths for the instruction fetch buffer
package ifetch_pkg;
    localparam int IF_W = 32;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } state_e;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: PC-tagged instruction queue with synchronous clear and head output
module fetch_fifo
    import ifetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      clrn,
    input  logic                      clr_i,
    input  logic                      push_i,
    input  logic                      pop_i,
    input  logic [2*IF_W-1:0]         wdata_i,
    output logic [2*IF_W-1:0]         head_o,
    output logic [$clog2(DEPTH):0]    count_o
);
    localparam int AW = $clog2(DEPTH);
    logic [2*IF_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]       cnt_q, cnt_d;
    always_comb begin
        wr_d  = clr_i ? '0 : wr_q + AW'(push_i);
        rd_d  = clr_i ? '0 : rd_q + AW'(pop_i);
        cnt_d = clr_i ? '0 : cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
    end
    // storage is cleared on reset so the head reads zero until the first push
    always_ff @(posedge clk) begin
        if (!clrn) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            if (push_i && !clr_i) mem_q[wr_q] <= wdata_i;
        end
    end
    assign head_o  = mem_q[rd_q];
    assign count_o = cnt_q;
endmodule

// File: rtl/ifetch_buf.sv
// ifetch_buf: one-request-per-PC fetch FSM feeding a small FIFO, drives PC hold,
// absorbs decode stalls and branch redirects.
module ifetch_buf
    import ifetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            clrn,
    input  logic [IF_W-1:0] pc,
    output logic            pc_hold,
    output logic            imem_req,
    output logic [IF_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [IF_W-1:0] imem_rdata,
    input  logic            redirect,
    input  logic            loaddepen,
    output logic [IF_W-1:0] inst,
    output logic [IF_W-1:0] inst_pc,
    output logic            inst_valid
);
    localparam int CW = $clog2(DEPTH) + 1;
    state_e            state_q, state_d;
    logic [IF_W-1:0]   addr_q, addr_d;
    logic [CW-1:0]     count;
    logic [2*IF_W-1:0] head;
    logic              push, pop;
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        push    = 1'b0;
        case (state_q)
            ST_IDLE: if (count < CW'(DEPTH) && !redirect) begin
                state_d = ST_WAIT;
                addr_d  = pc;
            end
            ST_WAIT: if (imem_ack) begin
                state_d = ST_IDLE;
                push    = !redirect;
            end else if (redirect) begin
                state_d = ST_DROP;
            end
            ST_DROP: if (imem_ack) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!clrn) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end
    // an ack racing a reset must not advance the PC
    assign pc_hold    = ~(redirect | (clrn & (state_q == ST_WAIT) & imem_ack));
    assign imem_req   = (state_q == ST_WAIT);
    assign imem_addr  = addr_q;
    assign inst_valid = (count != '0);
    assign pop        = inst_valid & ~loaddepen;
    assign inst_pc    = head[2*IF_W-1:IF_W];
    assign inst       = head[IF_W-1:0];
    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .clrn    (clrn),
        .clr_i   (redirect),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i ({addr_q, imem_rdata}),
        .head_o  (head),
        .count_o (count)
    );
endmodule
